// File: rtl/rob_if.sv
// Rename <-> reorder-buffer bundle: dispatch, writeback,
// flush, commit and dual rollback ports.
interface rob_if;
  logic       dis_valid;
  logic       dis_ready;
  logic [5:0] dis_A_rd;
  logic [6:0] dis_P_rd_new;
  logic [6:0] dis_P_rd_old;
  logic [3:0] dis_rob_idx;

  logic       wb_valid;
  logic [3:0] wb_rob_idx;

  logic       flush_valid;
  logic [3:0] flush_rob_idx;

  logic       commit_valid;
  logic       commit_wb_en;
  logic [5:0] commit_A_rd;
  logic [6:0] commit_P_rd_new;
  logic [6:0] commit_P_rd_old;
  logic [3:0] commit_rob_idx;

  logic       rollback_en_0;
  logic [5:0] rollback_A_rd_0;
  logic [6:0] rollback_P_rd_old_0;
  logic [6:0] rollback_P_rd_new_0;
  logic       rollback_en_1;
  logic [5:0] rollback_A_rd_1;
  logic [6:0] rollback_P_rd_old_1;
  logic [6:0] rollback_P_rd_new_1;
  logic       rollback_busy;

  modport master (
    output dis_valid, dis_A_rd,
    output dis_P_rd_new, dis_P_rd_old,
    input  dis_ready, dis_rob_idx,
    output wb_valid, wb_rob_idx,
    output flush_valid, flush_rob_idx,
    input  commit_valid, commit_wb_en,
    input  commit_A_rd, commit_P_rd_new,
    input  commit_P_rd_old, commit_rob_idx,
    input  rollback_en_0, rollback_A_rd_0,
    input  rollback_P_rd_old_0,
    input  rollback_P_rd_new_0,
    input  rollback_en_1, rollback_A_rd_1,
    input  rollback_P_rd_old_1,
    input  rollback_P_rd_new_1,
    input  rollback_busy
  );

  modport slave (
    input  dis_valid, dis_A_rd,
    input  dis_P_rd_new, dis_P_rd_old,
    output dis_ready, dis_rob_idx,
    input  wb_valid, wb_rob_idx,
    input  flush_valid, flush_rob_idx,
    output commit_valid, commit_wb_en,
    output commit_A_rd, commit_P_rd_new,
    output commit_P_rd_old, commit_rob_idx,
    output rollback_en_0, rollback_A_rd_0,
    output rollback_P_rd_old_0,
    output rollback_P_rd_new_0,
    output rollback_en_1, rollback_A_rd_1,
    output rollback_P_rd_old_1,
    output rollback_P_rd_new_1,
    output rollback_busy
  );
endinterface

// File: rtl/rob.sv
// 16-entry reorder buffer: in-order retire, two-wide
// backward rollback walk on branch flush.
module rob (
  input  logic clk,
  input  logic rst,
  rob_if.slave bus
);
  localparam int DEPTH = 16;

  typedef enum logic {IDLE, ROLLBACK} state_t;

  state_t           r_state;
  logic [5:0]       r_a  [DEPTH];
  logic [6:0]       r_pn [DEPTH];
  logic [6:0]       r_po [DEPTH];
  logic [DEPTH-1:0] r_done;
  logic [3:0]       r_head;
  logic [3:0]       r_tail;
  logic [3:0]       r_target;
  logic [4:0]       r_count;

  logic       w_ready;
  logic       w_accept;
  logic       w_commit;
  logic       w_rb;
  logic       w_en0;
  logic       w_en1;
  logic       w_fl_go;
  logic       w_retarget;
  logic [3:0] w_age_fl;
  logic [3:0] w_age_tg;
  logic [4:0] w_younger;
  logic [3:0] w_rem;
  logic [3:0] w_rem_rt;
  logic [3:0] w_t1;
  logic [3:0] w_t2;
  logic [1:0] w_rolled;
  logic [3:0] w_tail_nxt;
  logic       w_cv;
  logic       w_o0;
  logic       w_o1;

  assign w_rb     = (r_state == ROLLBACK);
  assign w_commit = (r_count != 5'd0)
                  && r_done[r_head];
  assign w_ready  = !rst && !w_rb
                  && !bus.flush_valid
                  && !r_count[4];
  assign w_accept = bus.dis_valid && w_ready;

  assign w_age_fl  = bus.flush_rob_idx - r_head;
  assign w_age_tg  = r_target - r_head;
  assign w_younger = r_count
                   - {1'b0, w_age_fl} - 5'd1;
  assign w_fl_go   = !w_rb && bus.flush_valid
                   && ({1'b0, w_age_fl} < r_count)
                   && (w_younger != 5'd0);

  // Tail-relative distance stays valid even if the
  // target itself retires while the walk is running.
  assign w_rem      = r_tail - r_target - 4'd1;
  assign w_t1       = r_tail - 4'd1;
  assign w_t2       = r_tail - 4'd2;
  assign w_en0      = w_rb && (w_rem != 4'd0);
  assign w_en1      = w_rb && (w_rem >= 4'd2);
  assign w_rolled   = {1'b0, w_en0} + {1'b0, w_en1};
  assign w_tail_nxt = r_tail - {2'b00, w_rolled};
  assign w_retarget = w_rb && bus.flush_valid
                    && (w_age_fl < w_age_tg);
  assign w_rem_rt   = w_tail_nxt
                    - bus.flush_rob_idx - 4'd1;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a[r_tail]  <= bus.dis_A_rd;
      r_pn[r_tail] <= bus.dis_P_rd_new;
      r_po[r_tail] <= bus.dis_P_rd_old;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_head   <= '0;
      r_tail   <= '0;
      r_target <= '0;
      r_count  <= '0;
      r_done   <= '0;
    end else begin
      if (bus.wb_valid)
        r_done[bus.wb_rob_idx] <= 1'b1;
      if (w_accept) begin
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 4'd1;
      end
      if (w_commit)
        r_head <= r_head + 4'd1;
      r_count <= r_count
               + {4'b0, w_accept}
               - {4'b0, w_commit}
               - {3'b0, w_rolled};
      case (r_state)
        IDLE: begin
          if (w_fl_go) begin
            r_target <= bus.flush_rob_idx;
            r_state  <= ROLLBACK;
          end
        end
        ROLLBACK: begin
          r_tail <= w_tail_nxt;
          if (w_retarget) begin
            r_target <= bus.flush_rob_idx;
            if (w_rem_rt == 4'd0)
              r_state <= IDLE;
          end else if (w_rem <= 4'd2) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_cv = !rst && w_commit;
  assign w_o0 = !rst && w_en0;
  assign w_o1 = !rst && w_en1;

  assign bus.dis_ready   = w_ready;
  assign bus.dis_rob_idx = rst ? 4'd0 : r_tail;

  assign bus.commit_valid    = w_cv;
  assign bus.commit_wb_en    = w_cv
                             && (r_pn[r_head] != 7'd0);
  assign bus.commit_A_rd     = w_cv ? r_a[r_head]  : '0;
  assign bus.commit_P_rd_new = w_cv ? r_pn[r_head] : '0;
  assign bus.commit_P_rd_old = w_cv ? r_po[r_head] : '0;
  assign bus.commit_rob_idx  = w_cv ? r_head : '0;

  assign bus.rollback_en_0       = w_o0;
  assign bus.rollback_A_rd_0     = w_o0 ? r_a[w_t1]  : '0;
  assign bus.rollback_P_rd_old_0 = w_o0 ? r_po[w_t1] : '0;
  assign bus.rollback_P_rd_new_0 = w_o0 ? r_pn[w_t1] : '0;
  assign bus.rollback_en_1       = w_o1;
  assign bus.rollback_A_rd_1     = w_o1 ? r_a[w_t2]  : '0;
  assign bus.rollback_P_rd_old_1 = w_o1 ? r_po[w_t2] : '0;
  assign bus.rollback_P_rd_new_1 = w_o1 ? r_pn[w_t2] : '0;
  assign bus.rollback_busy       = !rst && w_rb;
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: entries queued on dispatch,
// popped from the front on commit and the back on rollback.
module tb_rob;
  logic clk = 1'b0;
  logic rst;
  int   pass_n = 0;
  int   tot_n  = 0;

  typedef struct {
    logic [5:0] a;
    logic [6:0] pn;
    logic [6:0] po;
    logic [3:0] idx;
  } ent_t;

  ent_t       sb[$];
  logic [3:0] mtail;

  rob_if bus();
  rob dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic clr_in();
    bus.dis_valid     = 1'b0;
    bus.dis_A_rd      = '0;
    bus.dis_P_rd_new  = '0;
    bus.dis_P_rd_old  = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rob_idx    = '0;
    bus.flush_valid   = 1'b0;
    bus.flush_rob_idx = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mtail = 4'd0;
  endtask

  task automatic dis(input logic [5:0] a,
                     input logic [6:0] pn,
                     input logic [6:0] po,
                     output logic ok);
    bus.dis_valid    = 1'b1;
    bus.dis_A_rd     = a;
    bus.dis_P_rd_new = pn;
    bus.dis_P_rd_old = po;
    #1;
    ok = (bus.dis_ready === 1'b1)
      && (bus.dis_rob_idx === mtail);
    if (bus.dis_ready === 1'b1) begin
      sb.push_back('{a, pn, po, mtail});
      mtail = mtail + 4'd1;
    end
    @(negedge clk);
    bus.dis_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] idx);
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = idx;
    @(negedge clk);
    bus.wb_valid = 1'b0;
  endtask

  // Complete every live entry; returns commits seen and
  // how many disagreed with the scoreboard head.
  task automatic drain(output int n, output int bad);
    logic [3:0] ids[$];
    n = 0;
    bad = 0;
    foreach (sb[i]) ids.push_back(sb[i].idx);
    for (int c = 0; c < 40; c++) begin
      if (ids.size() > 0) begin
        bus.wb_valid   = 1'b1;
        bus.wb_rob_idx = ids.pop_front();
      end else begin
        bus.wb_valid = 1'b0;
      end
      #1;
      if (bus.commit_valid === 1'b1) begin
        n++;
        if (sb.size() == 0) bad++;
        else begin
          ent_t e;
          e = sb.pop_front();
          if (bus.commit_A_rd !== e.a
              || bus.commit_P_rd_new !== e.pn
              || bus.commit_P_rd_old !== e.po
              || bus.commit_rob_idx !== e.idx
              || bus.commit_wb_en !== (e.pn != 0))
            bad++;
        end
      end
      @(negedge clk);
    end
    bus.wb_valid = 1'b0;
  endtask

  task automatic rb_step(input int k, output int bad);
    ent_t e;
    bad = 0;
    #1;
    if (k >= 1) begin
      e = sb.pop_back();
      if (bus.rollback_en_0 !== 1'b1
          || bus.rollback_A_rd_0 !== e.a
          || bus.rollback_P_rd_new_0 !== e.pn
          || bus.rollback_P_rd_old_0 !== e.po)
        bad++;
    end else if (bus.rollback_en_0 !== 1'b0) bad++;
    if (k >= 2) begin
      e = sb.pop_back();
      if (bus.rollback_en_1 !== 1'b1
          || bus.rollback_A_rd_1 !== e.a
          || bus.rollback_P_rd_new_1 !== e.pn
          || bus.rollback_P_rd_old_1 !== e.po)
        bad++;
    end else if (bus.rollback_en_1 !== 1'b0) bad++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_in();
    @(negedge clk);
    @(negedge clk);
    #1;
    tot_n++;
    if ({bus.dis_ready, bus.commit_valid,
         bus.rollback_en_0, bus.rollback_en_1,
         bus.rollback_busy, bus.dis_rob_idx} !== 9'd0)
      $display("FAIL rst_outs: got %b want 0",
        {bus.dis_ready, bus.commit_valid,
         bus.rollback_en_0, bus.rollback_en_1,
         bus.rollback_busy, bus.dis_rob_idx});
    else pass_n++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mtail = 4'd0;
    #1;
    tot_n++;
    if (bus.dis_ready !== 1'b1
        || bus.commit_valid !== 1'b0
        || bus.rollback_en_0 !== 1'b0
        || bus.rollback_busy !== 1'b0)
      $display("FAIL post_rst: got rdy=%b cv=%b en0=%b bsy=%b want 1 0 0 0",
        bus.dis_ready, bus.commit_valid,
        bus.rollback_en_0, bus.rollback_busy);
    else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_fill_commit();
    logic ok;
    int nb;
    ent_t e;
    do_reset();
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      dis(6'(i), 7'(64 + i), 7'(i), ok);
      if (!ok) nb++;
    end
    tot_n++;
    if (nb !== 0)
      $display("FAIL fill_idx: got %0d bad want 0", nb);
    else pass_n++;
    #1;
    tot_n++;
    if (bus.dis_ready !== 1'b0)
      $display("FAIL full_ready: got %b want 0",
        bus.dis_ready);
    else pass_n++;
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 4'd3;
    @(negedge clk);
    bus.wb_rob_idx = 4'd0;
    #1;
    tot_n++;
    if (bus.commit_valid !== 1'b0)
      $display("FAIL early_commit: got %b want 0",
        bus.commit_valid);
    else pass_n++;
    @(negedge clk);
    bus.wb_rob_idx = 4'd1;
    bus.dis_valid  = 1'b1;
    #1;
    tot_n++;
    if (bus.dis_ready !== 1'b0)
      $display("FAIL full_commit_rdy: got %b want 0",
        bus.dis_ready);
    else pass_n++;
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        // already sampled above
      end else #1;
      e = sb.pop_front();
      if (bus.commit_valid !== 1'b1
          || bus.commit_rob_idx !== e.idx
          || bus.commit_P_rd_new !== e.pn
          || bus.commit_A_rd !== e.a
          || bus.commit_P_rd_old !== e.po
          || bus.commit_wb_en !== 1'b1)
        nb++;
      @(negedge clk);
      bus.dis_valid = 1'b0;
      if (c == 0) bus.wb_rob_idx = 4'd2;
      else bus.wb_valid = 1'b0;
    end
    tot_n++;
    if (nb !== 0)
      $display("FAIL commit_order: got %0d bad want 0", nb);
    else pass_n++;
    #1;
    tot_n++;
    if (bus.commit_valid !== 1'b0
        || bus.dis_rob_idx !== 4'd0)
      $display("FAIL after_commit: got cv=%b idx=%0d want 0 0",
        bus.commit_valid, bus.dis_rob_idx);
    else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_no_dest();
    logic ok;
    int n, nb;
    do_reset();
    dis(6'd5, 7'd0, 7'd9, ok);
    dis(6'd6, 7'd70, 7'd10, ok);
    wb(4'd0);
    #1;
    tot_n++;
    if (bus.commit_valid !== 1'b1
        || bus.commit_wb_en !== 1'b0
        || bus.commit_A_rd !== 6'd5
        || bus.commit_P_rd_old !== 7'd9)
      $display("FAIL nodest: got cv=%b we=%b a=%0d po=%0d want 1 0 5 9",
        bus.commit_valid, bus.commit_wb_en,
        bus.commit_A_rd, bus.commit_P_rd_old);
    else pass_n++;
    void'(sb.pop_front());
    @(negedge clk);
    drain(n, nb);
    tot_n++;
    if (n !== 1 || nb !== 0)
      $display("FAIL nodest_drain: got n=%0d bad=%0d want 1 0",
        n, nb);
    else pass_n++;
  endtask

  task automatic test_rollback_odd();
    logic ok;
    int n, nb, b;
    do_reset();
    for (int i = 0; i < 5; i++)
      dis(6'(10 + i), 7'(20 + i), 7'(40 + i), ok);
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd1;
    #1;
    tot_n++;
    if (bus.dis_ready !== 1'b0)
      $display("FAIL flush_rdy: got %b want 0",
        bus.dis_ready);
    else pass_n++;
    @(negedge clk);
    bus.flush_valid = 1'b0;
    #1;
    tot_n++;
    if (bus.rollback_busy !== 1'b1)
      $display("FAIL odd_busy: got %b want 1",
        bus.rollback_busy);
    else pass_n++;
    rb_step(2, b);
    nb = b;
    rb_step(1, b);
    nb += b;
    tot_n++;
    if (nb !== 0)
      $display("FAIL odd_rb: got %0d bad want 0", nb);
    else pass_n++;
    #1;
    tot_n++;
    if (bus.dis_ready !== 1'b1
        || bus.dis_rob_idx !== 4'd2
        || bus.rollback_busy !== 1'b0)
      $display("FAIL odd_end: got rdy=%b tail=%0d bsy=%b want 1 2 0",
        bus.dis_ready, bus.dis_rob_idx,
        bus.rollback_busy);
    else pass_n++;
    mtail = 4'd2;
    @(negedge clk);
    drain(n, nb);
    tot_n++;
    if (n !== 2 || nb !== 0)
      $display("FAIL odd_count: got n=%0d bad=%0d want 2 0",
        n, nb);
    else pass_n++;
  endtask

  task automatic test_wrap_rollback();
    logic ok;
    int n, nb, b;
    do_reset();
    for (int i = 0; i < 14; i++)
      dis(6'(i), 7'(1 + i), 7'(i), ok);
    drain(n, nb);
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      dis(6'(20 + i), 7'(80 + i), 7'(30 + i), ok);
      if (!ok) nb++;
    end
    tot_n++;
    if (nb !== 0 || n !== 14)
      $display("FAIL wrap_fill: got bad=%0d n=%0d want 0 14",
        nb, n);
    else pass_n++;
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd15;
    @(negedge clk);
    bus.flush_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 7; c++) begin
      rb_step(2, b);
      nb += b;
    end
    tot_n++;
    if (nb !== 0)
      $display("FAIL wrap_rb: got %0d bad want 0", nb);
    else pass_n++;
    #1;
    tot_n++;
    if (bus.dis_rob_idx !== 4'd0
        || bus.dis_ready !== 1'b1)
      $display("FAIL wrap_end: got tail=%0d rdy=%b want 0 1",
        bus.dis_rob_idx, bus.dis_ready);
    else pass_n++;
    mtail = 4'd0;
    @(negedge clk);
    drain(n, nb);
    tot_n++;
    if (n !== 2 || nb !== 0)
      $display("FAIL wrap_count: got n=%0d bad=%0d want 2 0",
        n, nb);
    else pass_n++;
  endtask

  task automatic test_retarget();
    logic ok;
    int n, nb, b;
    do_reset();
    for (int i = 0; i < 10; i++)
      dis(6'(i), 7'(100 + i), 7'(50 + i), ok);
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd6;
    @(negedge clk);
    bus.flush_rob_idx = 4'd2;
    rb_step(2, b);
    nb = b;
    bus.flush_rob_idx = 4'd8;
    rb_step(2, b);
    nb += b;
    bus.flush_valid = 1'b0;
    rb_step(2, b);
    nb += b;
    rb_step(1, b);
    nb += b;
    tot_n++;
    if (nb !== 0)
      $display("FAIL retarget_rb: got %0d bad want 0", nb);
    else pass_n++;
    #1;
    tot_n++;
    if (bus.dis_rob_idx !== 4'd3
        || bus.rollback_busy !== 1'b0)
      $display("FAIL retarget_end: got tail=%0d bsy=%b want 3 0",
        bus.dis_rob_idx, bus.rollback_busy);
    else pass_n++;
    mtail = 4'd3;
    @(negedge clk);
    drain(n, nb);
    tot_n++;
    if (n !== 3 || nb !== 0)
      $display("FAIL retarget_count: got n=%0d bad=%0d want 3 0",
        n, nb);
    else pass_n++;
  endtask

  task automatic test_commit_rb_reset();
    logic ok;
    int n, nb, b;
    ent_t e;
    do_reset();
    for (int i = 0; i < 3; i++)
      dis(6'(i), 7'(10 + i), 7'(i), ok);
    bus.wb_valid      = 1'b1;
    bus.wb_rob_idx    = 4'd0;
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd0;
    @(negedge clk);
    clr_in();
    #1;
    e = sb.pop_front();
    tot_n++;
    if (bus.commit_valid !== 1'b1
        || bus.commit_rob_idx !== e.idx)
      $display("FAIL cmt_final_rb: got cv=%b idx=%0d want 1 %0d",
        bus.commit_valid, bus.commit_rob_idx, e.idx);
    else pass_n++;
    rb_step(2, b);
    #1;
    tot_n++;
    if (b !== 0 || bus.dis_rob_idx !== 4'd1
        || bus.commit_valid !== 1'b0
        || bus.dis_ready !== 1'b1)
      $display("FAIL cmt_final_end: got bad=%0d tail=%0d cv=%b rdy=%b want 0 1 0 1",
        b, bus.dis_rob_idx, bus.commit_valid,
        bus.dis_ready);
    else pass_n++;
    mtail = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      dis(6'(30 + i), 7'(90 + i), 7'(60 + i), ok);
    bus.wb_valid      = 1'b1;
    bus.wb_rob_idx    = 4'd1;
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd2;
    @(negedge clk);
    clr_in();
    #1;
    e = sb.pop_front();
    tot_n++;
    if (bus.commit_valid !== 1'b1
        || bus.commit_P_rd_new !== e.pn
        || bus.rollback_en_0 !== 1'b1
        || bus.rollback_en_1 !== 1'b1)
      $display("FAIL cmt_and_rb: got cv=%b pn=%0d en=%b%b want 1 %0d 11",
        bus.commit_valid, bus.commit_P_rd_new,
        bus.rollback_en_0, bus.rollback_en_1, e.pn);
    else pass_n++;
    rb_step(2, b);
    tot_n++;
    if (b !== 0)
      $display("FAIL cmt_and_rb_ports: got %0d bad want 0", b);
    else pass_n++;
    rst = 1'b1;
    #1;
    tot_n++;
    if (bus.rollback_en_0 !== 1'b0
        || bus.rollback_busy !== 1'b0)
      $display("FAIL rst_hold: got en0=%b bsy=%b want 0 0",
        bus.rollback_en_0, bus.rollback_busy);
    else pass_n++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mtail = 4'd0;
    #1;
    tot_n++;
    if (bus.rollback_en_0 !== 1'b0
        || bus.rollback_en_1 !== 1'b0
        || bus.commit_valid !== 1'b0
        || bus.rollback_busy !== 1'b0
        || bus.dis_rob_idx !== 4'd0
        || bus.dis_ready !== 1'b1)
      $display("FAIL rst_mid_rb: got en=%b%b cv=%b bsy=%b tail=%0d rdy=%b want 00 0 0 0 1",
        bus.rollback_en_0, bus.rollback_en_1,
        bus.commit_valid, bus.rollback_busy,
        bus.dis_rob_idx, bus.dis_ready);
    else pass_n++;
    @(negedge clk);
    drain(n, nb);
    tot_n++;
    if (n !== 0)
      $display("FAIL rst_count: got %0d commits want 0", n);
    else pass_n++;
  endtask

  initial begin
    rst = 1'b1;
    mtail = 4'd0;
    clr_in();
    test_reset();
    test_fill_commit();
    test_no_dest();
    test_rollback_odd();
    test_wrap_rollback();
    test_retarget();
    test_commit_rb_reset();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
